// File: rtl/specinvert_pkg.sv
// Shared definitions for the spectral-inversion block: register offsets,
// compatibility value, packet FSM states and the beat sideband bundle.
package specinvert_pkg;

    localparam logic [19:0] REG_COMPAT    = 20'h00;
    localparam logic [19:0] REG_INVERT_EN = 20'h04;
    localparam logic [19:0] REG_STATUS    = 20'h08;
    localparam logic [19:0] REG_PKT_COUNT = 20'h0C;
    localparam logic [19:0] REG_CLEAR     = 20'h10;

    localparam logic [31:0] COMPAT_DEFAULT = 32'h0001_0000;

    typedef enum logic {
        ST_SOP = 1'b0,
        ST_MID = 1'b1
    } pkt_state_t;

    typedef struct packed {
        logic        keep;
        logic        last;
        logic [63:0] timestamp;
        logic        has_time;
        logic [15:0] length;
        logic        eov;
        logic        eob;
    } sideband_t;

endpackage

// File: rtl/specinvert_regs.sv
// CtrlPort decode and control/status registers; every request is answered
// exactly one cycle later, unmapped and write-only offsets read as zero.
module specinvert_regs
    import specinvert_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR = 20'h0,
    parameter logic [31:0] COMPAT    = COMPAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_wr,
    input  logic        req_rd,
    input  logic [19:0] req_addr,
    input  logic [31:0] req_data,
    output logic        resp_ack,
    output logic [31:0] resp_data,
    input  logic        active_en,
    input  logic [31:0] pkt_count,
    output logic        pending_en,
    output logic        clear_cnt
);

    logic [19:0] offset;
    logic [31:0] rd_value;
    logic        pending_q, pending_d;
    logic        ack_q, ack_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        unused_wdata;

    assign offset       = req_addr - BASE_ADDR;
    assign unused_wdata = ^req_data[31:1];

    always_comb begin
        rd_value = '0;
        case (offset)
            REG_COMPAT:    rd_value = COMPAT;
            REG_INVERT_EN: rd_value = {31'b0, pending_q};
            REG_STATUS:    rd_value = {30'b0, pending_q != active_en, active_en};
            REG_PKT_COUNT: rd_value = pkt_count;
            default:       rd_value = '0;
        endcase
    end

    always_comb begin
        pending_d   = pending_q;
        if (req_wr && offset == REG_INVERT_EN) begin
            pending_d = req_data[0];
        end
        ack_d       = req_wr || req_rd;
        resp_data_d = (req_rd && !req_wr) ? rd_value : '0;
    end

    // The clear strobe is combinational so it lands on the same edge as the write
    assign clear_cnt = req_wr && (offset == REG_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= 1'b0;
            ack_q       <= 1'b0;
            resp_data_q <= '0;
        end else begin
            pending_q   <= pending_d;
            ack_q       <= ack_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign pending_en = pending_q;
    assign resp_ack   = ack_q;
    assign resp_data  = resp_data_q;

endmodule

// File: rtl/specinvert_ctrl.sv
// Packet-aligned spectral inversion of sc16 samples (Q negated with saturation)
// behind a one-register AXI-Stream stage, with CtrlPort control and a packet counter.
module specinvert_ctrl
    import specinvert_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR = 20'h0,
    parameter logic [31:0] COMPAT    = COMPAT_DEFAULT
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        s_ctrlport_req_wr,
    input  logic        s_ctrlport_req_rd,
    input  logic [19:0] s_ctrlport_req_addr,
    input  logic [31:0] s_ctrlport_req_data,
    output logic        s_ctrlport_resp_ack,
    output logic [31:0] s_ctrlport_resp_data,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_ttimestamp,
    input  logic        s_axis_thas_time,
    input  logic [15:0] s_axis_tlength,
    input  logic        s_axis_teov,
    input  logic        s_axis_teob,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_ttimestamp,
    output logic        m_axis_thas_time,
    output logic [15:0] m_axis_tlength,
    output logic        m_axis_teov,
    output logic        m_axis_teob
);

    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] x);
        logic signed [15:0] r;
        if (x == 16'sh8000) r = 16'sh7FFF;
        else                r = -x;
        return r;
    endfunction

    logic               pending_en;
    logic               clear_cnt;
    logic               s_tready;
    logic               hs_in;
    logic               used_en;
    logic               active_q, active_d;
    pkt_state_t         state_q, state_d;
    logic [31:0]        pkt_count_q, pkt_count_d;
    logic signed [15:0] q_in;
    logic               vld_p1_q, vld_p1_d;
    logic [31:0]        data_p1_q, data_p1_d;
    sideband_t          sb_p1_q, sb_p1_d;

    specinvert_regs #(
        .BASE_ADDR (BASE_ADDR),
        .COMPAT    (COMPAT)
    ) u_regs (
        .clk        (ce_clk),
        .rst        (ce_rst),
        .req_wr     (s_ctrlport_req_wr),
        .req_rd     (s_ctrlport_req_rd),
        .req_addr   (s_ctrlport_req_addr),
        .req_data   (s_ctrlport_req_data),
        .resp_ack   (s_ctrlport_resp_ack),
        .resp_data  (s_ctrlport_resp_data),
        .active_en  (active_q),
        .pkt_count  (pkt_count_q),
        .pending_en (pending_en),
        .clear_cnt  (clear_cnt)
    );

    assign s_tready      = ce_rst || !vld_p1_q || m_axis_tready;
    assign s_axis_tready = s_tready;
    assign hs_in         = s_axis_tvalid && s_tready && !ce_rst;
    assign q_in          = s_axis_tdata[15:0];

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state_q     <= ST_SOP;
            active_q    <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (hs_in) begin
            state_d = s_axis_tlast ? ST_SOP : ST_MID;
        end
    end

    // Enable only changes hands at a packet start, so a packet is never split
    always_comb begin
        used_en  = (state_q == ST_SOP) ? pending_en : active_q;
        active_d = active_q;
        if (hs_in && state_q == ST_SOP) begin
            active_d = pending_en;
        end
    end

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (clear_cnt) begin
            pkt_count_d = '0;
        end else if (hs_in && s_axis_tlast) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
    end

    // Stage p1: output register, loaded whenever the upstream side is ready
    always_comb begin
        vld_p1_d  = vld_p1_q;
        data_p1_d = data_p1_q;
        sb_p1_d   = sb_p1_q;
        if (s_tready) begin
            vld_p1_d = s_axis_tvalid;
            if (s_axis_tvalid) begin
                data_p1_d = used_en ? {s_axis_tdata[31:16], neg_sat(q_in)} : s_axis_tdata;
                sb_p1_d   = {s_axis_tkeep, s_axis_tlast, s_axis_ttimestamp,
                             s_axis_thas_time, s_axis_tlength, s_axis_teov, s_axis_teob};
            end
        end
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            vld_p1_q  <= 1'b0;
            data_p1_q <= '0;
            sb_p1_q   <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            data_p1_q <= data_p1_d;
            sb_p1_q   <= sb_p1_d;
        end
    end

    assign m_axis_tvalid     = vld_p1_q;
    assign m_axis_tdata      = data_p1_q;
    assign m_axis_tkeep      = sb_p1_q.keep;
    assign m_axis_tlast      = sb_p1_q.last;
    assign m_axis_ttimestamp = sb_p1_q.timestamp;
    assign m_axis_thas_time  = sb_p1_q.has_time;
    assign m_axis_tlength    = sb_p1_q.length;
    assign m_axis_teov       = sb_p1_q.eov;
    assign m_axis_teob       = sb_p1_q.eob;

endmodule

// File: tb/tb_specinvert_ctrl.sv
// Directed and randomized-backpressure bench for specinvert_ctrl with a
// scoreboard fed at input handshakes and drained at output handshakes.
module tb_specinvert_ctrl;
    import specinvert_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        keep;
        logic        last;
        logic [63:0] ts;
        logic        ht;
        logic [15:0] len;
        logic        eov;
        logic        eob;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_wr = 1'b0, req_rd = 1'b0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        resp_ack;
    logic [31:0] resp_data;
    logic [31:0] s_tdata = '0;
    logic        s_tkeep = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
    logic [63:0] s_ts = '0;
    logic        s_ht = 1'b0, s_eov = 1'b0, s_eob = 1'b0;
    logic [15:0] s_len = '0;
    logic [31:0] m_tdata;
    logic        m_tkeep, m_tlast, m_tvalid, m_ht, m_eov, m_eob;
    logic [63:0] m_ts;
    logic [15:0] m_len;
    logic        bp_en = 1'b0, bp_rand = 1'b1, tready_dir = 1'b1;
    logic        m_tready;

    assign m_tready = bp_en ? bp_rand : tready_dir;

    specinvert_ctrl dut (
        .ce_clk               (clk),
        .ce_rst               (rst),
        .s_ctrlport_req_wr    (req_wr),
        .s_ctrlport_req_rd    (req_rd),
        .s_ctrlport_req_addr  (req_addr),
        .s_ctrlport_req_data  (req_data),
        .s_ctrlport_resp_ack  (resp_ack),
        .s_ctrlport_resp_data (resp_data),
        .s_axis_tdata         (s_tdata),
        .s_axis_tkeep         (s_tkeep),
        .s_axis_tlast         (s_tlast),
        .s_axis_tvalid        (s_tvalid),
        .s_axis_tready        (s_tready),
        .s_axis_ttimestamp    (s_ts),
        .s_axis_thas_time     (s_ht),
        .s_axis_tlength       (s_len),
        .s_axis_teov          (s_eov),
        .s_axis_teob          (s_eob),
        .m_axis_tdata         (m_tdata),
        .m_axis_tkeep         (m_tkeep),
        .m_axis_tlast         (m_tlast),
        .m_axis_tvalid        (m_tvalid),
        .m_axis_tready        (m_tready),
        .m_axis_ttimestamp    (m_ts),
        .m_axis_thas_time     (m_ht),
        .m_axis_tlength       (m_len),
        .m_axis_teov          (m_eov),
        .m_axis_teob          (m_eob)
    );

    int          errors = 0;
    int          checks = 0;
    int          n_in = 0;
    int          n_out = 0;
    beat_t       sb_q[$];
    logic        mdl_pend = 1'b0, mdl_act = 1'b0, mdl_sop = 1'b1;
    int unsigned mdl_cnt = 0;
    logic [31:0] last_exp = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat_neg(input logic [15:0] q);
        if (q == 16'h8000) return 16'h7FFF;
        return 16'h0000 - q;
    endfunction

    // Reference model: applied at the moment a beat is accepted
    function automatic void accept(input beat_t b);
        logic  en;
        beat_t e;
        en = mdl_sop ? mdl_pend : mdl_act;
        if (mdl_sop) mdl_act = mdl_pend;
        mdl_sop = b.last;
        e = b;
        if (en) e.data[15:0] = sat_neg(b.data[15:0]);
        if (b.last) mdl_cnt++;
        sb_q.push_back(e);
        last_exp = e.data;
        n_in++;
    endfunction

    // Output monitor: scoreboard pop and hold-under-backpressure check
    beat_t mon_cur, mon_exp, prev_out;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        mon_cur = {m_tdata, m_tkeep, m_tlast, m_ts, m_ht, m_len, m_eov, m_eob};
        if (prev_stall) chk("hold", 128'({m_tvalid, mon_cur}), 128'({1'b1, prev_out}));
        prev_stall = m_tvalid && !m_tready && !rst;
        prev_out   = mon_cur;
        if (m_tvalid && m_tready && !rst) begin
            n_out++;
            chk("out_has_expected", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                chk("beat", 128'(mon_cur), 128'(mon_exp));
            end
        end
    end

    always @(posedge clk) begin
        #1 bp_rand = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(input logic [31:0] d, input logic l);
        beat_t b;
        b      = '0;
        b.data = d;
        b.last = l;
        b.keep = 1'b1;
        b.ts   = {32'h0000_00A5, d};
        b.len  = 16'd8;
        return b;
    endfunction

    task automatic send_beat(input beat_t b, input logic [31:0] exp_data, input bit use_exp);
        bit done;
        done = 0;
        s_tdata = b.data; s_tkeep = b.keep; s_tlast = b.last; s_ts = b.ts;
        s_ht = b.ht; s_len = b.len; s_eov = b.eov; s_eob = b.eob; s_tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_tready) begin
                accept(b);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        chk("accept", 128'(done), 128'(1));
        if (done) chk("latency1", 128'({m_tvalid, m_tdata}),
                      128'({1'b1, use_exp ? exp_data : last_exp}));
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) tick();
        chk("drain", 128'(sb_q.size()), 128'(0));
    endtask

    task automatic ctrl_read(input logic [19:0] off, input logic [31:0] exp, input string tag);
        req_rd = 1'b1; req_addr = off;
        tick();
        req_rd = 1'b0;
        chk({tag, "_ack"}, 128'(resp_ack), 128'(1));
        chk(tag, 128'(resp_data), 128'(exp));
    endtask

    task automatic ctrl_write(input logic [19:0] off, input logic [31:0] d, input string tag);
        req_wr = 1'b1; req_addr = off; req_data = d;
        tick();
        req_wr = 1'b0;
        chk({tag, "_ack"}, 128'({resp_ack, resp_data}), 128'({1'b1, 32'h0}));
        if (off == REG_INVERT_EN) mdl_pend = d[0];
        if (off == REG_CLEAR) mdl_cnt = 0;
    endtask

    initial begin
        beat_t b;
        // Reset state
        repeat (3) tick();
        chk("rst_s_tready", 128'(s_tready), 128'(1));
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_resp", 128'({resp_ack, resp_data}), 128'(0));
        chk("rst_m_out", 128'({m_tdata, m_tkeep, m_tlast, m_ts, m_ht, m_len, m_eov, m_eob}), 128'(0));
        rst = 1'b0;
        tick();

        // Register map basics
        ctrl_read(REG_COMPAT, 32'h0001_0000, "compat");
        ctrl_read(20'h3C, 32'h0, "unmapped");
        tick();
        chk("ack_single_cycle", 128'(resp_ack), 128'(0));
        ctrl_write(REG_COMPAT, 32'hDEAD_BEEF, "wr_ro");
        ctrl_read(REG_COMPAT, 32'h0001_0000, "compat_after_wr");
        ctrl_read(REG_CLEAR, 32'h0, "rd_wo");

        // Enable at a packet boundary
        ctrl_write(REG_INVERT_EN, 32'h1, "wr_en1");
        ctrl_read(REG_INVERT_EN, 32'h1, "invert_en");
        ctrl_read(REG_STATUS, 32'h2, "status_pending");
        for (int i = 0; i < 4; i++) send_beat(mk(32'h1234_0005, i == 3), 32'h1234_FFFB, 1);
        idle();
        drain();
        ctrl_read(REG_STATUS, 32'h1, "status_active");

        // Saturating negation of Q
        send_beat(mk(32'hABCD_8000, 1'b1), 32'hABCD_7FFF, 1);
        send_beat(mk(32'hABCD_7FFF, 1'b1), 32'hABCD_8001, 1);
        send_beat(mk(32'hABCD_0000, 1'b1), 32'hABCD_0000, 1);
        idle();
        drain();

        // Enable write coinciding with an SOP beat: the beat uses the old pending value
        req_wr = 1'b1; req_addr = REG_INVERT_EN; req_data = 32'h0;
        send_beat(mk(32'h0000_0007, 1'b1), 32'h0000_FFF9, 1);
        req_wr = 1'b0;
        mdl_pend = 1'b0;
        chk("coinc_wr_ack", 128'({resp_ack, resp_data}), 128'({1'b1, 32'h0}));
        send_beat(mk(32'h0000_0007, 1'b1), 32'h0000_0007, 1);
        idle();
        drain();

        // Mid-packet enable
        send_beat(mk(32'h0000_0010, 1'b0), 32'h0000_0010, 1);
        send_beat(mk(32'h0000_0010, 1'b0), 32'h0000_0010, 1);
        req_wr = 1'b1; req_addr = REG_INVERT_EN; req_data = 32'h1;
        send_beat(mk(32'h0000_0010, 1'b0), 32'h0000_0010, 1);
        req_wr = 1'b0;
        mdl_pend = 1'b1;
        idle();
        ctrl_read(REG_STATUS, 32'h2, "status_mid");
        for (int i = 3; i < 8; i++) send_beat(mk(32'h0000_0010, i == 7), 32'h0000_0010, 1);
        send_beat(mk(32'h0000_0010, 1'b0), 32'h0000_FFF0, 1);
        send_beat(mk(32'h0000_0010, 1'b1), 32'h0000_FFF0, 1);
        idle();
        drain();
        ctrl_read(REG_STATUS, 32'h1, "status_next_pkt");

        // Random backpressure stream with occasional enable changes
        bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 99) begin
                idle();
                ctrl_write(REG_INVERT_EN, 32'($urandom_range(0, 1)), "wr_en_rand");
            end
            b.data = $urandom;
            if ($urandom_range(0, 7) == 0) b.data[15:0] = 16'h8000;
            b.keep = 1'($urandom_range(0, 1));
            b.last = ($urandom_range(0, 3) == 0);
            b.ts   = {$urandom, $urandom};
            b.ht   = 1'($urandom_range(0, 1));
            b.len  = 16'($urandom);
            b.eov  = 1'($urandom_range(0, 1));
            b.eob  = 1'($urandom_range(0, 1));
            send_beat(b, 32'h0, 0);
        end
        idle();
        drain();
        bp_en = 1'b0;
        tick();
        chk("beat_count", 128'(n_out), 128'(n_in));
        ctrl_read(REG_PKT_COUNT, 32'(mdl_cnt), "pkt_count_stream");

        // Counter wrap, read-vs-increment and clear-vs-increment
        idle();
        if (!mdl_sop) begin
            send_beat(mk(32'h0000_0001, 1'b1), 32'h0, 0);
            idle();
        end
        force dut.pkt_count_q = 32'hFFFF_FFFE;
        tick();
        release dut.pkt_count_q;
        mdl_cnt = 32'hFFFF_FFFE;
        ctrl_read(REG_PKT_COUNT, 32'hFFFF_FFFE, "cnt_preload");
        for (int i = 0; i < 3; i++) send_beat(mk(32'h0000_0002, 1'b1), 32'h0, 0);
        idle();
        ctrl_read(REG_PKT_COUNT, 32'h1, "cnt_wrap");
        req_rd = 1'b1; req_addr = REG_PKT_COUNT;
        send_beat(mk(32'h0000_0003, 1'b1), 32'h0, 0);
        req_rd = 1'b0;
        chk("cnt_rd_coinc", 128'({resp_ack, resp_data}), 128'({1'b1, 32'h1}));
        idle();
        ctrl_read(REG_PKT_COUNT, 32'h2, "cnt_after_rd");
        req_wr = 1'b1; req_addr = REG_CLEAR; req_data = 32'h0;
        send_beat(mk(32'h0000_0004, 1'b1), 32'h0, 0);
        req_wr = 1'b0;
        mdl_cnt = 0;
        idle();
        ctrl_read(REG_PKT_COUNT, 32'h0, "cnt_clear_wins");
        drain();
        chk("beat_count_final", 128'(n_out), 128'(n_in));

        // Reset in the middle of a packet with a beat held at the output
        send_beat(mk(32'h0000_0005, 1'b1), 32'h0, 0);
        send_beat(mk(32'h1111_2222, 1'b0), 32'h0, 0);
        idle();
        tready_dir = 1'b0;
        tick();
        chk("held_before_rst", 128'(m_tvalid), 128'(1));
        ctrl_read(REG_PKT_COUNT, 32'h1, "cnt_before_rst");
        rst = 1'b1;
        req_rd = 1'b1; req_addr = REG_COMPAT;
        tick();
        chk("rst_mid_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_mid_tready", 128'(s_tready), 128'(1));
        chk("rst_mid_out", 128'({m_tdata, m_tlast, m_ts, m_len}), 128'(0));
        chk("rst_mid_noack", 128'({resp_ack, resp_data}), 128'(0));
        tick();
        chk("rst_mid_noack2", 128'(resp_ack), 128'(0));
        req_rd = 1'b0;
        rst = 1'b0;
        sb_q.delete();
        mdl_pend = 1'b0; mdl_act = 1'b0; mdl_sop = 1'b1; mdl_cnt = 0;
        tready_dir = 1'b1;
        tick();
        chk("post_rst_noack", 128'(resp_ack), 128'(0));
        ctrl_read(REG_PKT_COUNT, 32'h0, "cnt_after_rst");
        ctrl_read(REG_STATUS, 32'h0, "status_after_rst");
        ctrl_write(REG_INVERT_EN, 32'h1, "wr_en_post_rst");
        send_beat(mk(32'h0001_0003, 1'b1), 32'h0001_FFFD, 1);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/specinvert_ctrl.md
SPECINVERT_CTRL -- requirements
Module: specinvert_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 20'h0, giving the CtrlPort byte address of register offset 0.
REQ-002 SHALL have parameter COMPAT, default 32'h0001_0000, giving the compatibility value {major[31:16], minor[15:0]}.
REQ-003 ce_clk  in  1  sole clock; all ports are synchronous to it.
REQ-004 ce_rst  in  1  synchronous, active-high reset.
REQ-005 s_ctrlport_req_wr / s_ctrlport_req_rd  in  1 each  single-cycle write/read strobes.
REQ-006 s_ctrlport_req_addr  in  20  byte address; s_ctrlport_req_data  in  32  write data.
REQ-007 s_ctrlport_resp_ack  out  1  response strobe; s_ctrlport_resp_data  out  32  read data.
REQ-008 s_axis_tdata  in  32  sc16 sample, I in [31:16], Q in [15:0]; s_axis_tkeep  in  1; s_axis_tlast/tvalid  in  1; s_axis_tready  out  1.
REQ-009 s_axis_ttimestamp  in  64; s_axis_thas_time  in  1; s_axis_tlength  in  16; s_axis_teov/teob  in  1 each; packet sideband.
REQ-010 m_axis_* out (tready in): the same set of ports as s_axis_*, with the same widths, in the opposite direction.

Function
REQ-011 Register map, as offsets from BASE_ADDR:
  - 0x00 COMPAT: RO.
  - 0x04 INVERT_EN: RW, bit0 = pending enable.
  - 0x08 STATUS: RO, bit0 = active enable, bit1 = (pending != active).
  - 0x0C PKT_COUNT: RO, 32 bits.
  - 0x10 CLEAR: WO, any write zeroes PKT_COUNT.
REQ-012 Every req_wr or req_rd SHALL produce resp_ack exactly one cycle later, including unmapped addresses.
REQ-013 resp_data SHALL return the register value for mapped readable addresses, and 0 for writes, unmapped addresses and WO offsets.
REQ-014 Writes to RO or unmapped offsets SHALL be ignored. Register bits not defined in REQ-011 SHALL read 0.
REQ-015 Packet FSM with two states:
  - SOP to MID on an input handshake with tlast=0.
  - MID to SOP on an input handshake with tlast=1.
  - SOP stays SOP on a handshake with tlast=1 (single-beat packet).
REQ-016 Enable used for a beat: pending when the FSM is in SOP, otherwise active. active SHALL load pending on every handshake taken in SOP.
  - A pending change therefore never takes effect mid-packet.
REQ-017 With the used enable = 1, output Q SHALL be -Q, saturating -32768 to 32767. I SHALL pass unchanged.
REQ-018 With the used enable = 0, tdata SHALL pass bit-exact.
REQ-019 tkeep, tlast, ttimestamp, thas_time, tlength, teov and teob SHALL pass unchanged, aligned with their beat.
REQ-020 Datapath SHALL be a single register stage:
  - latency 1 cycle.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - full throughput of 1 beat/cycle with no bubbles.
REQ-021 m_axis outputs SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 PKT_COUNT SHALL increment on each input handshake with tlast=1 and wrap from 0xFFFF_FFFF to 0.
REQ-023 A CLEAR write coinciding with a count increment SHALL leave PKT_COUNT = 0 (clear wins).
REQ-024 A CtrlPort read of PKT_COUNT coinciding with an increment SHALL return the pre-increment value.
REQ-025 An INVERT_EN write in the same cycle as an SOP handshake SHALL take effect from the next packet; the current beat uses the old pending value.

Reset
REQ-026 ce_rst=1 SHALL set the following, with no CtrlPort response generated for requests presented during reset:
  - m_axis_tvalid = 0
  - resp_ack = 0, resp_data = 0
  - pending = 0, active = 0
  - PKT_COUNT = 0
  - FSM = SOP
REQ-027 During reset, s_axis_tready SHALL be 1. m_axis_tdata and the m_axis sideband outputs SHALL be 0.
REQ-028 Reset mid-packet SHALL discard the held beat. The next input beat after reset SHALL be treated as a start of packet.

Structure
REQ-029 Shared package specinvert_pkg SHALL hold:
  - the register offsets.
  - the COMPAT default.
  - the FSM state enum {ST_SOP, ST_MID}.
REQ-030 One sub-module, specinvert_regs, SHALL implement the CtrlPort decode and registers and output pending_en. The datapath, FSM and counter remain in the top level.

Verification
REQ-031 Enable at packet boundary: write INVERT_EN=1, then send a 4-beat packet of 0x1234_0005 -> every output beat 0x1234_FFFB; STATUS reads 0x1.
REQ-032 Mid-packet enable: write INVERT_EN=1 during beat 2 of an 8-beat packet of 0x0000_0010 -> all 8 beats unchanged, STATUS bit1=1 during the packet; the next packet's beats read 0x0000_FFF0.
REQ-033 Saturation: with enable=1, send Q=0x8000, 0x7FFF and 0x0000 -> outputs 0x7FFF, 0x8001 and 0x0000 respectively.
REQ-034 Backpressure: drive m_axis_tready with a random 50% duty over 1000 beats -> no loss, duplication or reorder, sideband aligned with its beat, 1-cycle latency when tready=1.
REQ-035 Counter: preload 0xFFFF_FFFE via 2^32-2 packets (force allowed), send 3 single-beat packets -> read 1; CLEAR write coincident with tlast -> read 0.
REQ-036 Reset/CtrlPort checks: assert ce_rst mid-packet -> m_axis_tvalid=0 next cycle and PKT_COUNT=0; read of 0x3C -> ack after 1 cycle, data 0; read of 0x00 -> 0x0001_0000.
